// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO write path: default widths,
// the packing ratio and a width-compatibility check.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_ACCUM = 1'b1
  } pack_state_e;

  function automatic int calc_ratio(input int in_w, input int data_w);
    return data_w / in_w;
  endfunction

  function automatic bit widths_ok(input int in_w, input int data_w);
    return (in_w > 0) && (data_w % in_w == 0);
  endfunction

endpackage

// File: rtl/fifo_wr_packer_if.sv
// Narrow beat stream in, FIFO write port out. The packer takes the master view.
interface fifo_wr_packer_if #(
  parameter int IN_WIDTH   = 2,
  parameter int DATA_WIDTH = 8
);
  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  Wr_enable;
  logic                  full_flag;

  modport master (
    input  in_data, in_valid, in_last, full_flag,
    output in_ready, data_in, Wr_enable
  );

  modport slave (
    output in_data, in_valid, in_last, full_flag,
    input  in_ready, data_in, Wr_enable
  );
endinterface

// File: rtl/fifo_wr_packer.sv
// Packs RATIO narrow beats (first beat in the LSBs) into one FIFO word, flushes
// partial words on in_last, and counts written words and accepted packets.
module fifo_wr_packer
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH   = 2,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_write,
  input  logic                  rst,
  fifo_wr_packer_if.master      bus,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_cnt
);

  localparam int RATIO  = calc_ratio(IN_WIDTH, DATA_WIDTH);
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (!widths_ok(IN_WIDTH, DATA_WIDTH)) begin : g_bad_width
    $error("fifo_wr_packer: DATA_WIDTH must be a multiple of IN_WIDTH");
  end

  pack_state_e           state_q, state_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;

  logic                  wr_en;
  logic                  ready;
  logic                  accept;
  logic                  complete;
  logic [DATA_WIDTH-1:0] merged;

  // Ready only looks at the output register, so a blocked word stalls every beat.
  assign wr_en = out_valid_q && !bus.full_flag;
  assign ready = !out_valid_q || !bus.full_flag;

  assign bus.Wr_enable = wr_en;
  assign bus.in_ready  = ready;
  assign bus.data_in   = out_q;
  assign word_cnt      = word_cnt_q;
  assign pkt_cnt       = pkt_cnt_q;

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    word_cnt_d  = word_cnt_q + CNT_WIDTH'(wr_en);
    pkt_cnt_d   = pkt_cnt_q;

    accept   = bus.in_valid && ready;
    complete = accept && (bus.in_last || (lane_q == LANE_W'(RATIO - 1)));

    merged = acc_q;
    merged[int'(lane_q) * IN_WIDTH +: IN_WIDTH] = bus.in_data;

    if (wr_en) begin
      out_valid_d = 1'b0;
    end

    if (accept && bus.in_last) begin
      pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
    end

    case (state_q)
      ST_EMPTY, ST_ACCUM: begin
        if (complete) begin
          out_d       = merged;
          out_valid_d = 1'b1;
          acc_d       = '0;
          lane_d      = '0;
          state_d     = ST_EMPTY;
        end else if (accept) begin
          acc_d   = merged;
          lane_d  = lane_q + LANE_W'(1);
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        lane_d  = '0;
        acc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_write or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      lane_q      <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      word_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      word_cnt_q  <= word_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Bench for fifo_wr_packer: directed scenarios plus random traffic, all checked
// against a queue-based model of packets, pending words and counters.
module tb_fifo_wr_packer;

  localparam int IN_W   = 2;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int RATIO  = DATA_W / IN_W;
  localparam int CNT_MASK = (1 << CNT_W) - 1;

  logic             clk_write = 1'b0;
  logic             rst       = 1'b0;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] pkt_cnt;

  fifo_wr_packer_if #(.IN_WIDTH(IN_W), .DATA_WIDTH(DATA_W)) bus ();

  fifo_wr_packer #(
    .IN_WIDTH  (IN_W),
    .DATA_WIDTH(DATA_W),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clk_write(clk_write),
    .rst      (rst),
    .bus      (bus),
    .word_cnt (word_cnt),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 clk_write = ~clk_write;

  int beats[$];
  int exp_q[$];
  int m_words;
  int m_pkts;
  int last_wr;
  int n_pass;
  int n_total;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    beats.delete();
    exp_q.delete();
    m_words = 0;
    m_pkts  = 0;
    last_wr = -1;
  endtask

  // One clock: drive on the falling edge, check just after, then advance the model.
  task automatic step(input bit v, input int d, input bit l, input bit f, output bit acc);
    bit exp_ready;
    bit exp_wr;
    int w;
    @(negedge clk_write);
    bus.in_valid  = v;
    bus.in_data   = d[IN_W-1:0];
    bus.in_last   = l;
    bus.full_flag = f;
    #1;
    exp_ready = !(exp_q.size() > 0 && f);
    exp_wr    = (exp_q.size() > 0) && !f;
    check_val("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check_val("wr_enable", 32'(bus.Wr_enable), 32'(exp_wr));
    if (exp_q.size() > 0) check_val("data_in", 32'(bus.data_in), exp_q[0]);
    check_val("word_cnt", 32'(word_cnt), m_words & CNT_MASK);
    check_val("pkt_cnt", 32'(pkt_cnt), m_pkts & CNT_MASK);
    if (exp_wr) begin
      last_wr = int'(bus.data_in);
      void'(exp_q.pop_front());
      m_words++;
    end
    acc = v && exp_ready;
    if (acc) begin
      beats.push_back(d & ((1 << IN_W) - 1));
      if (l) m_pkts++;
      if (l || beats.size() == RATIO) begin
        w = 0;
        foreach (beats[k]) w += beats[k] << (k * IN_W);
        exp_q.push_back(w);
        beats.delete();
      end
    end
  endtask

  task automatic send(input int d, input bit l, input bit f);
    bit acc;
    for (int t = 0; t < 40; t++) begin
      step(1'b1, d, l, f, acc);
      if (acc) return;
    end
    n_total++;
    $display("FAIL send_timeout: beat %0d never accepted", d);
  endtask

  task automatic idle(input int n, input bit f);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, f, acc);
  endtask

  task automatic do_reset();
    @(negedge clk_write);
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus.full_flag = 1'b0;
    #1;
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("rst_wr_enable", 32'(bus.Wr_enable), 32'd0);
    check_val("rst_data_in", 32'(bus.data_in), 32'd0);
    check_val("rst_word_cnt", 32'(word_cnt), 32'd0);
    check_val("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    model_clear();
    @(negedge clk_write);
    rst = 1'b1;
  endtask

  initial begin
    bit acc;
    n_pass  = 0;
    n_total = 0;
    model_clear();
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus.full_flag = 1'b0;
    do_reset();

    // Full word, no last
    send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(0, 0, 0);
    idle(2, 0);
    check_val("t1_word", last_wr, 32'h39);
    check_val("t1_word_cnt", 32'(word_cnt), 32'd1);

    // Two-beat packet, then one-beat packet
    do_reset();
    send(3, 0, 0); send(3, 1, 0);
    idle(2, 0);
    check_val("t2_word", last_wr, 32'h0F);
    check_val("t2_pkt_cnt", 32'(pkt_cnt), 32'd1);
    send(2, 1, 0);
    idle(2, 0);
    check_val("t3_word", last_wr, 32'h02);

    // Last on the final lane gives a single word
    do_reset();
    send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(3, 1, 0);
    idle(3, 0);
    check_val("t4_word_cnt", 32'(word_cnt), 32'd1);
    check_val("t4_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Backpressure while full
    do_reset();
    send(1, 0, 1); send(1, 0, 1); send(1, 0, 1); send(1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2, 1'b0, 1'b1, acc);
      check_val("bp_hold", 32'(bus.data_in), 32'h55);
      check_val("bp_accept", 32'(acc), 32'd0);
    end
    send(2, 0, 0); send(2, 0, 0); send(2, 0, 0); send(2, 0, 0);
    idle(2, 0);
    check_val("bp_word", last_wr, 32'hAA);
    check_val("bp_word_cnt", 32'(word_cnt), 32'd2);

    // Reset mid-word discards the partial
    do_reset();
    send(3, 0, 0); send(3, 0, 0);
    do_reset();
    send(0, 0, 0); send(0, 0, 0); send(0, 0, 0); send(1, 0, 0);
    idle(2, 0);
    check_val("rst_mid_word", last_wr, 32'h40);
    check_val("rst_mid_word_cnt", 32'(word_cnt), 32'd1);

    // Sustained throughput
    do_reset();
    for (int i = 0; i < 16; i++) send(3, 0, 0);
    idle(2, 0);
    check_val("tp_word", last_wr, 32'hFF);
    check_val("tp_word_cnt", 32'(word_cnt), 32'd4);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0), acc);
    end
    idle(3, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
